ifu_fetch: RTL and testbench

- Instruction fetch unit directly upstream of the decode/execute datapath.
- Issues instruction reads to memory over a valid/ready address channel and a valid/ready read-data channel, then presents `{inst, inst_pc}` to decode with a valid/ready handshake.
- Waits for the downstream stage to return the next PC before fetching again.
- Replaces the combinational same-cycle instruction read with a multi-cycle, latency-tolerant fetch.

---
 rtl/ifu_fetch.sv | 155 +++++++++++++++
 tb/tb_ifu_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding valid/ready read per instruction, result
// presented to decode, next fetch gated on the PC update returned by execute.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [31:0] pc_upd,
  input  logic        pc_upd_valid,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    OUT  = 3'd3,
    WAIT = 3'd4
  } state_t;

  localparam logic        WD_EN    = (TIMEOUT != 32'd0);
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT - 32'd1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] inst_pc_r;
  logic        inst_err_r;
  logic [31:0] fetch_cnt_r;
  logic [31:0] wd_cnt_r;

  logic        aligned_s;
  logic        take_pc_s;
  logic        resp_ok_s;
  logic        abort_s;
  logic        wd_inc_s;
  logic        cnt_inc_s;

  assign aligned_s  = (pc_upd[1:0] == 2'b00);

  assign araddr     = pc_r;
  assign arvalid    = (state_r == REQ);
  assign rready     = (state_r == RESP);
  assign inst_valid = (state_r == OUT);
  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;
  assign inst_err   = inst_err_r;
  assign fetch_cnt  = fetch_cnt_r;

  // Next-state decode and datapath load strobes.
  always_comb begin
    state_nxt_s = state_r;
    take_pc_s   = 1'b0;
    resp_ok_s   = 1'b0;
    abort_s     = 1'b0;
    wd_inc_s    = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_r)
      BOOT: state_nxt_s = REQ;
      REQ: begin
        if (arready) state_nxt_s = RESP;
        else         state_nxt_s = REQ;
      end
      RESP: begin
        if (rvalid) begin
          resp_ok_s   = 1'b1;
          state_nxt_s = OUT;
        end else if (WD_EN && (wd_cnt_r == WD_LIMIT)) begin
          abort_s     = 1'b1;
          state_nxt_s = OUT;
        end else begin
          wd_inc_s    = 1'b1;
          state_nxt_s = RESP;
        end
      end
      OUT: begin
        if (inst_ready) begin
          cnt_inc_s = 1'b1;
          if (pc_upd_valid) begin
            take_pc_s   = 1'b1;
            state_nxt_s = aligned_s ? REQ : OUT;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = OUT;
        end
      end
      WAIT: begin
        if (pc_upd_valid) begin
          take_pc_s   = 1'b1;
          state_nxt_s = aligned_s ? REQ : OUT;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= BOOT;
    else      state_r <= state_nxt_s;
  end

  // PC, presented instruction, watchdog and handshake counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r        <= RESET_PC;
      inst_r      <= 32'd0;
      inst_pc_r   <= 32'd0;
      inst_err_r  <= 1'b0;
      fetch_cnt_r <= 32'd0;
      wd_cnt_r    <= 32'd0;
    end else begin
      if (take_pc_s && aligned_s) pc_r <= pc_upd;

      if (resp_ok_s) begin
        inst_r     <= rdata;
        inst_pc_r  <= pc_r;
        inst_err_r <= (rresp != 2'b00);
      end else if (abort_s) begin
        inst_r     <= 32'd0;
        inst_pc_r  <= pc_r;
        inst_err_r <= 1'b1;
      end else if (take_pc_s && !aligned_s) begin
        // misaligned target never reaches the bus; decode sees an error slot
        inst_r     <= 32'd0;
        inst_pc_r  <= pc_upd;
        inst_err_r <= 1'b1;
      end

      if (resp_ok_s || abort_s) wd_cnt_r <= 32'd0;
      else if (wd_inc_s)        wd_cnt_r <= wd_cnt_r + 32'd1;

      if (cnt_inc_s) fetch_cnt_r <= fetch_cnt_r + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a default-timeout instance for the fetch flow and a
// TIMEOUT=4 instance for the watchdog and mid-RESP reset.
module tb_ifu_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        rst, arready, rvalid, inst_ready, pc_upd_valid;
  logic [31:0] rdata, pc_upd;
  logic [1:0]  rresp;
  logic [31:0] araddr, inst, inst_pc, fetch_cnt;
  logic        arvalid, rready, inst_err, inst_valid;

  logic        w_rst, w_arready, w_rvalid, w_inst_ready, w_pc_upd_valid;
  logic [31:0] w_rdata, w_pc_upd;
  logic [1:0]  w_rresp;
  logic [31:0] w_araddr, w_inst, w_inst_pc, w_fetch_cnt;
  logic        w_arvalid, w_rready, w_inst_err, w_inst_valid;

  ifu_fetch dut (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .pc_upd(pc_upd), .pc_upd_valid(pc_upd_valid),
    .fetch_cnt(fetch_cnt)
  );

  ifu_fetch #(.TIMEOUT(4)) dut_wd (
    .clk(clk), .rst(w_rst), .araddr(w_araddr), .arvalid(w_arvalid), .arready(w_arready),
    .rdata(w_rdata), .rresp(w_rresp), .rvalid(w_rvalid), .rready(w_rready),
    .inst(w_inst), .inst_pc(w_inst_pc), .inst_err(w_inst_err), .inst_valid(w_inst_valid),
    .inst_ready(w_inst_ready), .pc_upd(w_pc_upd), .pc_upd_valid(w_pc_upd_valid),
    .fetch_cnt(w_fetch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are checked 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
    inst_ready = 1'b0; pc_upd = 32'd0; pc_upd_valid = 1'b0;
    w_rst = 1'b0; w_arready = 1'b0; w_rvalid = 1'b0; w_rdata = 32'd0; w_rresp = 2'b00;
    w_inst_ready = 1'b0; w_pc_upd = 32'd0; w_pc_upd_valid = 1'b0;
    step(); step();

    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_err", {31'd0, inst_err}, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_araddr", araddr, 32'h8000_0000);

    // basic fetch
    rst = 1'b1; arready = 1'b1; inst_ready = 1'b1;
    step();
    chk("boot_arvalid", {31'd0, arvalid}, 32'd1);
    chk("boot_araddr", araddr, 32'h8000_0000);
    step();
    chk("resp_rready", {31'd0, rready}, 32'd1);
    chk("resp_arvalid", {31'd0, arvalid}, 32'd0);
    chk("resp_inst_valid", {31'd0, inst_valid}, 32'd0);
    rvalid = 1'b1; rdata = 32'h0000_0413;
    step();
    rvalid = 1'b0;
    chk("f1_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("f1_inst", inst, 32'h0000_0413);
    chk("f1_inst_pc", inst_pc, 32'h8000_0000);
    chk("f1_inst_err", {31'd0, inst_err}, 32'd0);
    chk("f1_cnt_pre", fetch_cnt, 32'd0);
    step();
    chk("f1_cnt", fetch_cnt, 32'd1);
    chk("f1_wait_valid", {31'd0, inst_valid}, 32'd0);
    chk("f1_wait_arvalid", {31'd0, arvalid}, 32'd0);

    // WAIT -> REQ, then arready stall with a stray rvalid that must be ignored
    pc_upd_valid = 1'b1; pc_upd = 32'h8000_0008; arready = 1'b0;
    step();
    pc_upd_valid = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    chk("f2_arvalid", {31'd0, arvalid}, 32'd1);
    chk("f2_araddr", araddr, 32'h8000_0008);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_arvalid", {31'd0, arvalid}, 32'd1);
      chk("stall_araddr", araddr, 32'h8000_0008);
      chk("stall_rready", {31'd0, rready}, 32'd0);
    end
    rvalid = 1'b0; arready = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("rdelay_rready", {31'd0, rready}, 32'd1);
      chk("rdelay_valid", {31'd0, inst_valid}, 32'd0);
    end
    rvalid = 1'b1; rdata = 32'h0010_0093; inst_ready = 1'b0;
    step();
    rvalid = 1'b0;
    chk("f2_inst", inst, 32'h0010_0093);
    chk("f2_inst_pc", inst_pc, 32'h8000_0008);

    // backpressure
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_inst", inst, 32'h0010_0093);
      chk("bp_cnt", fetch_cnt, 32'd1);
    end
    inst_ready = 1'b1; pc_upd_valid = 1'b1; pc_upd = 32'h8000_0004;
    step();
    chk("direct_arvalid", {31'd0, arvalid}, 32'd1);
    chk("direct_araddr", araddr, 32'h8000_0004);
    chk("direct_cnt", fetch_cnt, 32'd2);
    chk("direct_valid", {31'd0, inst_valid}, 32'd0);
    pc_upd = 32'h1234_0000;
    step();
    pc_upd_valid = 1'b0;
    chk("ign_pcupd_araddr", araddr, 32'h8000_0004);
    chk("ign_pcupd_rready", {31'd0, rready}, 32'd1);

    // bus error
    rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
    step();
    rvalid = 1'b0; rresp = 2'b00;
    chk("berr_err", {31'd0, inst_err}, 32'd1);
    chk("berr_inst", inst, 32'hDEAD_BEEF);
    chk("berr_inst_pc", inst_pc, 32'h8000_0004);
    step();
    chk("berr_cnt", fetch_cnt, 32'd3);

    // misaligned PC update
    pc_upd_valid = 1'b1; pc_upd = 32'h8000_0102;
    step();
    pc_upd_valid = 1'b0;
    chk("mis_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mis_valid", {31'd0, inst_valid}, 32'd1);
    chk("mis_err", {31'd0, inst_err}, 32'd1);
    chk("mis_inst_pc", inst_pc, 32'h8000_0102);
    chk("mis_inst", inst, 32'd0);
    chk("mis_araddr", araddr, 32'h8000_0004);
    step();
    chk("mis_cnt", fetch_cnt, 32'd4);

    // watchdog instance, TIMEOUT=4
    w_rst = 1'b1; w_arready = 1'b1;
    step();
    step();
    chk("wd_enter_rready", {31'd0, w_rready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wd_pending_valid", {31'd0, w_inst_valid}, 32'd0);
      chk("wd_pending_rready", {31'd0, w_rready}, 32'd1);
    end
    step();
    chk("wd_abort_valid", {31'd0, w_inst_valid}, 32'd1);
    chk("wd_abort_err", {31'd0, w_inst_err}, 32'd1);
    chk("wd_abort_inst", w_inst, 32'd0);
    chk("wd_abort_inst_pc", w_inst_pc, 32'h8000_0000);
    chk("wd_abort_rready", {31'd0, w_rready}, 32'd0);
    w_rvalid = 1'b1; w_rdata = 32'hFFFF_FFFF;
    step();
    w_rvalid = 1'b0;
    chk("wd_late_inst", w_inst, 32'd0);
    chk("wd_late_valid", {31'd0, w_inst_valid}, 32'd1);
    w_inst_ready = 1'b1;
    step();
    chk("wd_cnt", w_fetch_cnt, 32'd1);
    w_pc_upd_valid = 1'b1; w_pc_upd = 32'h8000_0040;
    step();
    w_pc_upd_valid = 1'b0;
    chk("wd_req_araddr", w_araddr, 32'h8000_0040);
    step();
    chk("wd_resp2_rready", {31'd0, w_rready}, 32'd1);
    w_rst = 1'b0;
    step();
    chk("mid_rst_arvalid", {31'd0, w_arvalid}, 32'd0);
    chk("mid_rst_rready", {31'd0, w_rready}, 32'd0);
    chk("mid_rst_valid", {31'd0, w_inst_valid}, 32'd0);
    chk("mid_rst_inst", w_inst, 32'd0);
    chk("mid_rst_inst_pc", w_inst_pc, 32'd0);
    chk("mid_rst_err", {31'd0, w_inst_err}, 32'd0);
    chk("mid_rst_cnt", w_fetch_cnt, 32'd0);
    chk("mid_rst_araddr", w_araddr, 32'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
